// File: rtl/vending_machine_multi.sv
// -----------------------------------------------------------------------------
// vending_machine_multi
//
// Parametrised vending controller. It accepts nickel, dime, quarter and dollar
// strobes into a binary credit accumulator and dispenses one item when the
// credit reaches PRICE. Any remainder, or the full credit on a cancel, is
// returned greedily as a stream of one coin per cycle (25/10/5).
//
// Parameters
//   PRICE     item price in cents. It must be a multiple of 5 and lie in the
//             range 5..2^CREDIT_W-101.
//   CREDIT_W  width of the credit register. It must hold PRICE+99.
//
// Ports
//   clock        system clock, rising edge
//   rstn         asynchronous active-low reset
//   N_in         nickel (5c) accepted strobe
//   Dm_in        dime (10c) accepted strobe
//   Q_in         quarter (25c) accepted strobe
//   D_in         dollar (100c) accepted strobe
//   Cancel       refund request strobe
//   Dispense     one-cycle pulse: release one item
//   Change       one-cycle pulse: return one coin of type Change_coin
//   Change_coin  0=nickel, 1=dime, 2=quarter; 0 when Change=0
//   Reject       one-cycle pulse: the coin presented is bounced back
//   Credit       current credit in cents (accrued, or change still owed)
//   Busy         high while paying out change
//
// All outputs are registered. A response appears in the cycle after the edge
// that samples the input.
// -----------------------------------------------------------------------------
module vending_machine_multi #(
   parameter int PRICE    = 75,
   parameter int CREDIT_W = 8
) (
   input  logic                clock,
   input  logic                rstn,
   input  logic                N_in,
   input  logic                Dm_in,
   input  logic                Q_in,
   input  logic                D_in,
   input  logic                Cancel,
   output logic                Dispense,
   output logic                Change,
   output logic [1:0]          Change_coin,
   output logic                Reject,
   output logic [CREDIT_W-1:0] Credit,
   output logic                Busy
);

   typedef enum logic {
      ACCUM  = 1'b0,
      CHANGE = 1'b1
   } state_t;

   // The sum is computed one bit wider so that the PRICE comparison can never
   // wrap, even if the parameters are set at the edge of the legal range.
   localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);

   localparam logic [1:0] COIN_NICKEL  = 2'd0;
   localparam logic [1:0] COIN_DIME    = 2'd1;
   localparam logic [1:0] COIN_QUARTER = 2'd2;

   state_t              state;
   logic [2:0]          coin_cnt;
   logic                any_coin;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W:0]   over;
   logic [CREDIT_W-1:0] pay_val;
   logic [1:0]          pay_code;
   logic [CREDIT_W-1:0] pay_rem;
   logic                pay_last;

   // ---------------------------------------------------------------------------
   // Coin decode
   // ---------------------------------------------------------------------------
   assign coin_cnt = 3'(N_in) + 3'(Dm_in) + 3'(Q_in) + 3'(D_in);
   assign any_coin = (coin_cnt != 3'd0);

   // The value is only consumed when exactly one strobe is high, so the
   // priority order here does not matter functionally.
   always_comb begin
      coin_val = '0;
      if (D_in)       coin_val = (CREDIT_W+1)'(100);
      else if (Q_in)  coin_val = (CREDIT_W+1)'(25);
      else if (Dm_in) coin_val = (CREDIT_W+1)'(10);
      else if (N_in)  coin_val = (CREDIT_W+1)'(5);
   end

   assign sum  = {1'b0, Credit} + coin_val;
   assign over = sum - PRICE_X;

   // ---------------------------------------------------------------------------
   // Greedy payout selection
   // ---------------------------------------------------------------------------
   always_comb begin
      pay_val  = CREDIT_W'(5);
      pay_code = COIN_NICKEL;
      if (Credit >= CREDIT_W'(25)) begin
         pay_val  = CREDIT_W'(25);
         pay_code = COIN_QUARTER;
      end else if (Credit >= CREDIT_W'(10)) begin
         pay_val  = CREDIT_W'(10);
         pay_code = COIN_DIME;
      end
   end

   // Owed change is always a multiple of 5. The "<=" test still guarantees
   // that a corrupted credit value drains to zero rather than wrapping.
   assign pay_last = (Credit <= pay_val);
   assign pay_rem  = pay_last ? '0 : (Credit - pay_val);

   // ---------------------------------------------------------------------------
   // Controller: state, credit and all pulse outputs are registered together
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state       <= ACCUM;
         Credit      <= '0;
         Dispense    <= 1'b0;
         Change      <= 1'b0;
         Change_coin <= COIN_NICKEL;
         Reject      <= 1'b0;
         Busy        <= 1'b0;
      end else begin
         Dispense    <= 1'b0;
         Change      <= 1'b0;
         Change_coin <= COIN_NICKEL;
         Reject      <= 1'b0;

         case (state)
            ACCUM: begin
               if (Cancel && (Credit != '0)) begin
                  // Cancel wins. A coin offered in the same cycle is bounced.
                  state  <= CHANGE;
                  Busy   <= 1'b1;
                  Reject <= any_coin;
               end else if (coin_cnt > 3'd1) begin
                  Reject <= 1'b1;
               end else if (coin_cnt == 3'd1) begin
                  if (sum >= PRICE_X) begin
                     Dispense <= 1'b1;
                     Credit   <= CREDIT_W'(over);
                     if (over != '0) begin
                        state <= CHANGE;
                        Busy  <= 1'b1;
                     end
                  end else begin
                     Credit <= CREDIT_W'(sum);
                  end
               end
            end

            CHANGE: begin
               // Exactly one reject pulse per cycle, however many strobes are
               // high. Cancel has no effect while change is being paid out.
               Reject      <= any_coin;
               Change      <= 1'b1;
               Change_coin <= pay_code;
               Credit      <= pay_rem;
               if (pay_last) begin
                  state <= ACCUM;
                  Busy  <= 1'b0;
               end
            end

            default: begin
               state  <= ACCUM;
               Busy   <= 1'b0;
               Credit <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vending_machine_multi.sv
// -----------------------------------------------------------------------------
// Testbench for vending_machine_multi (PRICE=75, CREDIT_W=8).
//
// Each step drives one cycle of inputs and pushes the expected registered
// outputs to a queue. The entry is popped and compared #1 after the sampling
// edge.
// -----------------------------------------------------------------------------
module tb_vending_machine_multi;

   localparam int PRICE    = 75;
   localparam int CREDIT_W = 8;

   typedef struct {
      int disp;
      int chg;
      int coin;
      int rej;
      int credit;
      int busy;
   } exp_t;

   logic                clock;
   logic                rstn;
   logic                N_in, Dm_in, Q_in, D_in, Cancel;
   logic                Dispense, Change, Reject, Busy;
   logic [1:0]          Change_coin;
   logic [CREDIT_W-1:0] Credit;

   exp_t sb_q[$];
   int   vectors;
   int   miscompares;

   vending_machine_multi #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
      .clock       (clock),
      .rstn        (rstn),
      .N_in        (N_in),
      .Dm_in       (Dm_in),
      .Q_in        (Q_in),
      .D_in        (D_in),
      .Cancel      (Cancel),
      .Dispense    (Dispense),
      .Change      (Change),
      .Change_coin (Change_coin),
      .Reject      (Reject),
      .Credit      (Credit),
      .Busy        (Busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".disp"},   int'(Dispense),    0);
      chk({tag, ".chg"},    int'(Change),      0);
      chk({tag, ".coin"},   int'(Change_coin), 0);
      chk({tag, ".rej"},    int'(Reject),      0);
      chk({tag, ".credit"}, int'(Credit),      0);
      chk({tag, ".busy"},   int'(Busy),        0);
   endtask

   // The bit order of ins is {N, Dm, Q, D, Cancel}.
   task automatic step(input string tag, input logic [4:0] ins,
                       input int disp, input int chg, input int coin,
                       input int rej, input int credit, input int busy);
      exp_t e;
      exp_t got;
      {N_in, Dm_in, Q_in, D_in, Cancel} = ins;
      e.disp = disp; e.chg = chg; e.coin = coin;
      e.rej = rej; e.credit = credit; e.busy = busy;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      {N_in, Dm_in, Q_in, D_in, Cancel} = 5'b0;
      got = sb_q.pop_front();
      chk({tag, ".disp"},   int'(Dispense),    got.disp);
      chk({tag, ".chg"},    int'(Change),      got.chg);
      chk({tag, ".coin"},   int'(Change_coin), got.coin);
      chk({tag, ".rej"},    int'(Reject),      got.rej);
      chk({tag, ".credit"}, int'(Credit),      got.credit);
      chk({tag, ".busy"},   int'(Busy),        got.busy);
   endtask

   localparam logic [4:0] IDLE = 5'b00000;
   localparam logic [4:0] NK   = 5'b10000;
   localparam logic [4:0] DM   = 5'b01000;
   localparam logic [4:0] QU   = 5'b00100;
   localparam logic [4:0] DL   = 5'b00010;
   localparam logic [4:0] CN   = 5'b00001;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstn   = 1'b0;
      {N_in, Dm_in, Q_in, D_in, Cancel} = 5'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_idle_outputs("reset");
      rstn = 1'b1;

      // Three quarters reach the price exactly.
      step("q1",   QU,   0, 0, 0, 0, 25, 0);
      step("q2",   QU,   0, 0, 0, 0, 50, 0);
      step("q3",   QU,   1, 0, 0, 0,  0, 0);
      step("q3i",  IDLE, 0, 0, 0, 0,  0, 0);

      // A single dollar pays one quarter of change.
      step("d1",   DL,   1, 0, 0, 0, 25, 1);
      step("d1c",  IDLE, 0, 1, 2, 0,  0, 0);
      step("d1i",  IDLE, 0, 0, 0, 0,  0, 0);

      // A quarter followed by a dollar pays two quarters of change.
      step("qd_q", QU,   0, 0, 0, 0, 25, 0);
      step("qd_d", DL,   1, 0, 0, 0, 50, 1);
      step("qd_c1",IDLE, 0, 1, 2, 0, 25, 1);
      step("qd_c2",IDLE, 0, 1, 2, 0,  0, 0);
      step("qd_i", IDLE, 0, 0, 0, 0,  0, 0);

      // Cancel refunds 15 cents as a dime and then a nickel.
      step("cx_dm",DM,   0, 0, 0, 0, 10, 0);
      step("cx_n", NK,   0, 0, 0, 0, 15, 0);
      step("cx_cn",CN,   0, 0, 0, 0, 15, 1);
      step("cx_c1",IDLE, 0, 1, 1, 0,  5, 1);
      step("cx_c2",IDLE, 0, 1, 0, 0,  0, 0);
      step("cx_i", IDLE, 0, 0, 0, 0,  0, 0);

      // Multiple coin strobes are rejected, with zero and with nonzero credit.
      step("mc0",  QU|NK,0, 0, 0, 1,  0, 0);
      step("mc_q", QU,   0, 0, 0, 0, 25, 0);
      step("mc1",  DM|DL,0, 0, 0, 1, 25, 0);
      // A coin during payout is rejected and the payout continues.
      step("rj_d", DL,   1, 0, 0, 0, 50, 1);
      step("rj_c1",QU,   0, 1, 2, 1, 25, 1);
      step("rj_c2",NK|DM,0, 1, 2, 1,  0, 0);
      step("rj_i", IDLE, 0, 0, 0, 0,  0, 0);

      // Cancel with zero credit is ignored and the coin is processed.
      step("c0",   DM|CN,0, 0, 0, 0, 10, 0);
      // Cancel with credit wins over a simultaneous coin.
      step("cw",   QU|CN,0, 0, 0, 1, 10, 1);
      step("cw_c", IDLE, 0, 1, 1, 0,  0, 0);
      step("cw_i", IDLE, 0, 0, 0, 0,  0, 0);

      // Cancel is ignored during payout.
      step("ci_d", DL,   1, 0, 0, 0, 25, 1);
      step("ci_c", CN,   0, 1, 2, 0,  0, 0);
      step("ci_i", CN,   0, 0, 0, 0,  0, 0);

      // Greedy refund of 40 cents: 25, 10, 5.
      step("g_q",  QU,   0, 0, 0, 0, 25, 0);
      step("g_dm", DM,   0, 0, 0, 0, 35, 0);
      step("g_n",  NK,   0, 0, 0, 0, 40, 0);
      step("g_cn", CN,   0, 0, 0, 0, 40, 1);
      step("g_c1", IDLE, 0, 1, 2, 0, 15, 1);
      step("g_c2", IDLE, 0, 1, 1, 0,  5, 1);
      step("g_c3", IDLE, 0, 1, 0, 0,  0, 0);

      // Maximum sum is 70+100=170, which leaves 95 to pay as 25,25,25,10,10.
      step("m_q1", QU,   0, 0, 0, 0, 25, 0);
      step("m_q2", QU,   0, 0, 0, 0, 50, 0);
      step("m_d1", DM,   0, 0, 0, 0, 60, 0);
      step("m_d2", DM,   0, 0, 0, 0, 70, 0);
      step("m_dl", DL,   1, 0, 0, 0, 95, 1);
      step("m_c1", IDLE, 0, 1, 2, 0, 70, 1);
      step("m_c2", IDLE, 0, 1, 2, 0, 45, 1);
      step("m_c3", IDLE, 0, 1, 2, 0, 20, 1);
      step("m_c4", IDLE, 0, 1, 1, 0, 10, 1);
      step("m_c5", IDLE, 0, 1, 1, 0,  0, 0);
      step("m_i",  IDLE, 0, 0, 0, 0,  0, 0);

      // Reset asserted mid-change clears all outputs immediately.
      step("r_d",  DL,   1, 0, 0, 0, 25, 1);
      rstn = 1'b0;
      #1;
      chk_idle_outputs("r_async");
      @(posedge clock);
      #1;
      chk_idle_outputs("r_hold");
      rstn = 1'b1;
      step("r_q",  QU,   0, 0, 0, 0, 25, 0);
      step("r_i",  IDLE, 0, 0, 0, 0, 25, 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
